// File: rtl/ring_phase_decoder.sv
// ring_phase_decoder
//
// Receives the q vector of a one-hot ring counter, checks that every sample is
// one-hot and that consecutive samples follow the ring's rotation order
// (the 1 moves from bit i to bit i-1, and from bit 0 to bit WIDTH-1), decodes
// the active bit to a binary phase index and counts completed rotations.
// Downstream logic should trust index only while locked is high.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset (priority over sample_en)
//   sample_en    ring_in is taken on a rising edge only when this is 1
//   ring_in      one-hot ring state from the ring counter
//   index        bit position of the 1 in the last locked sample
//   locked       1 while the tracker is in LOCKED
//   step_err     one-cycle pulse: legal one-hot but wrong successor while LOCKED
//   illegal_err  one-cycle pulse: sampled ring_in not one-hot
//   rot_count    completed rotations while LOCKED, modulo 2^ROT_W
module ring_phase_decoder #(
    parameter int WIDTH      = 4,
    parameter int LOCK_COUNT = 2,
    parameter int ROT_W      = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sample_en,
    input  logic [WIDTH-1:0]         ring_in,
    output logic [$clog2(WIDTH)-1:0] index,
    output logic                     locked,
    output logic                     step_err,
    output logic                     illegal_err,
    output logic [ROT_W-1:0]         rot_count
);

    localparam int IDX_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // True when exactly one bit is set: non-zero and clearing the lowest set bit leaves nothing.
    function automatic logic is_one_hot(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] lowest_cleared;
        lowest_cleared = v & (v - {{(WIDTH-1){1'b0}}, 1'b1});
        return (v != '0) && (lowest_cleared == '0);
    endfunction

    // Position of the set bit; only meaningful for a one-hot argument.
    function automatic logic [IDX_W-1:0] one_hot_pos(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] pos;
        pos = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) begin
                pos = IDX_W'(i);
            end else begin
                pos = pos;
            end
        end
        return pos;
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [3:0]       good_cnt_q, good_cnt_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic             locked_q, locked_d;
    logic             step_err_q, step_err_d;
    logic             illegal_err_q, illegal_err_d;
    logic [ROT_W-1:0] rot_count_q, rot_count_d;

    logic             legal_s;
    logic             is_expected_s;
    logic             is_repeat_s;
    logic [WIDTH-1:0] expected_s;
    logic [3:0]       good_inc_s;

    // Sample classification against the previous accepted ring value.
    always_comb begin
        expected_s    = {prev_q[0], prev_q[WIDTH-1:1]};
        legal_s       = is_one_hot(ring_in);
        is_expected_s = legal_s && (ring_in == expected_s);
        is_repeat_s   = legal_s && (ring_in == prev_q);
        good_inc_s    = good_cnt_q + 4'd1;
    end

    // Next-state and output computation; everything holds unless a sample is taken.
    always_comb begin
        state_d       = state_q;
        prev_d        = prev_q;
        good_cnt_d    = good_cnt_q;
        index_d       = index_q;
        rot_count_d   = rot_count_q;
        step_err_d    = 1'b0;
        illegal_err_d = 1'b0;

        if (sample_en) begin
            case (state_q)
                ST_SEARCH: begin
                    if (legal_s) begin
                        prev_d     = ring_in;
                        good_cnt_d = 4'd0;
                        state_d    = ST_TRACK;
                    end else begin
                        illegal_err_d = 1'b1;
                    end
                end
                ST_TRACK: begin
                    if (!legal_s) begin
                        illegal_err_d = 1'b1;
                        good_cnt_d    = 4'd0;
                        state_d       = ST_SEARCH;
                    end else if (is_expected_s) begin
                        prev_d = ring_in;
                        if (good_inc_s == 4'(LOCK_COUNT)) begin
                            good_cnt_d = 4'd0;
                            index_d    = one_hot_pos(ring_in);
                            state_d    = ST_LOCKED;
                        end else begin
                            good_cnt_d = good_inc_s;
                        end
                    end else if (is_repeat_s) begin
                        // Stalled counter: no progress, no error.
                        state_d = ST_TRACK;
                    end else begin
                        // Legal jump while not yet locked restarts the run silently.
                        prev_d     = ring_in;
                        good_cnt_d = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    if (!legal_s) begin
                        illegal_err_d = 1'b1;
                        good_cnt_d    = 4'd0;
                        state_d       = ST_SEARCH;
                    end else if (is_expected_s) begin
                        prev_d  = ring_in;
                        index_d = one_hot_pos(ring_in);
                        // Leaving bit 0 means the 1 wrapped to the top: one full turn done.
                        if (prev_q[0]) begin
                            rot_count_d = rot_count_q + ROT_W'(1);
                        end else begin
                            rot_count_d = rot_count_q;
                        end
                    end else if (is_repeat_s) begin
                        state_d = ST_LOCKED;
                    end else begin
                        step_err_d = 1'b1;
                        prev_d     = ring_in;
                        good_cnt_d = 4'd0;
                        state_d    = ST_TRACK;
                    end
                end
                default: begin
                    good_cnt_d = 4'd0;
                    state_d    = ST_SEARCH;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        locked_d = (state_d == ST_LOCKED);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_SEARCH;
            prev_q        <= '0;
            good_cnt_q    <= 4'd0;
            index_q       <= '0;
            locked_q      <= 1'b0;
            step_err_q    <= 1'b0;
            illegal_err_q <= 1'b0;
            rot_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            prev_q        <= prev_d;
            good_cnt_q    <= good_cnt_d;
            index_q       <= index_d;
            locked_q      <= locked_d;
            step_err_q    <= step_err_d;
            illegal_err_q <= illegal_err_d;
            rot_count_q   <= rot_count_d;
        end
    end

    assign index       = index_q;
    assign locked      = locked_q;
    assign step_err    = step_err_q;
    assign illegal_err = illegal_err_q;
    assign rot_count   = rot_count_q;

endmodule

// File: tb/tb_ring_phase_decoder.sv
module tb_ring_phase_decoder;

    localparam int W     = 4;
    localparam int LC    = 2;
    localparam int ROT_W = 8;

    logic             clk;
    logic             reset;
    logic             sample_en;
    logic [W-1:0]     ring_in;
    logic [1:0]       index;
    logic             locked;
    logic             step_err;
    logic             illegal_err;
    logic [ROT_W-1:0] rot_count;

    int checks = 0;
    int errors = 0;

    ring_phase_decoder #(.WIDTH(W), .LOCK_COUNT(LC), .ROT_W(ROT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .sample_en  (sample_en),
        .ring_in    (ring_in),
        .index      (index),
        .locked     (locked),
        .step_err   (step_err),
        .illegal_err(illegal_err),
        .rot_count  (rot_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: tracks the ring as a bit position, mode 0/1/2 = search/track/locked.
    int m_mode     = 0;
    int m_prev_pos = -1;
    int m_good     = 0;
    int m_index    = 0;
    int m_rot      = 0;
    int m_step     = 0;
    int m_ill      = 0;

    always @(posedge clk) begin
        int ones;
        int pos;
        int exp_pos;
        m_step = 0;
        m_ill  = 0;
        if (reset) begin
            m_mode = 0; m_prev_pos = -1; m_good = 0; m_index = 0; m_rot = 0;
        end else if (sample_en) begin
            ones = 0;
            pos  = 0;
            for (int i = 0; i < W; i++) begin
                if (ring_in[i]) begin
                    ones++;
                    pos = i;
                end
            end
            exp_pos = (m_prev_pos + W - 1) % W;
            if (ones != 1) begin
                m_ill = 1;
                m_mode = 0;
                m_good = 0;
            end else if (m_mode == 0) begin
                m_mode = 1; m_prev_pos = pos; m_good = 0;
            end else if (pos == exp_pos) begin
                if (m_mode == 2) begin
                    if (m_prev_pos == 0) m_rot = (m_rot + 1) % (1 << ROT_W);
                    m_index = pos;
                end else begin
                    m_good++;
                    if (m_good == LC) begin
                        m_mode = 2; m_good = 0; m_index = pos;
                    end
                end
                m_prev_pos = pos;
            end else if (pos == m_prev_pos) begin
                // stalled ring counter: nothing moves
            end else begin
                if (m_mode == 2) m_step = 1;
                m_mode = 1; m_prev_pos = pos; m_good = 0;
            end
        end
    end

    // Continuous comparison of every output against the model, away from the active edge.
    always @(negedge clk) begin
        checks += 5;
        if (locked !== (m_mode == 2)) begin
            errors++; $display("FAIL locked: got %0b want %0b at %0t", locked, (m_mode == 2), $time);
        end
        if (index !== 2'(m_index)) begin
            errors++; $display("FAIL index: got %0d want %0d at %0t", index, m_index, $time);
        end
        if (rot_count !== ROT_W'(m_rot)) begin
            errors++; $display("FAIL rot_count: got %0d want %0d at %0t", rot_count, m_rot, $time);
        end
        if (step_err !== 1'(m_step)) begin
            errors++; $display("FAIL step_err: got %0b want %0d at %0t", step_err, m_step, $time);
        end
        if (illegal_err !== 1'(m_ill)) begin
            errors++; $display("FAIL illegal_err: got %0b want %0d at %0t", illegal_err, m_ill, $time);
        end
    end

    // Apply one edge worth of inputs; returns just after the edge has been taken.
    task automatic drive(input logic rst, input logic en, input logic [W-1:0] val);
        reset     = rst;
        sample_en = en;
        ring_in   = val;
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pin_state(input string tag, input int lk, input int idx, input int rot,
                             input int se, input int ie);
        chk({tag, ".locked"}, int'(locked), lk);
        chk({tag, ".index"}, int'(index), idx);
        chk({tag, ".rot_count"}, int'(rot_count), rot);
        chk({tag, ".step_err"}, int'(step_err), se);
        chk({tag, ".illegal_err"}, int'(illegal_err), ie);
    endtask

    initial begin
        int gen_pos;
        int r;
        logic [W-1:0] v;

        reset = 1'b1; sample_en = 1'b0; ring_in = 4'b0000;
        drive(1'b1, 1'b0, 4'b0000);
        drive(1'b1, 1'b0, 4'b0000);
        pin_state("reset", 0, 0, 0, 0, 0);

        // Lock after two correct successors.
        drive(1'b0, 1'b1, 4'b1000);
        drive(1'b0, 1'b1, 4'b0100);
        chk("lock.pre", int'(locked), 0);
        drive(1'b0, 1'b1, 4'b0010);
        pin_state("lock", 1, 1, 0, 0, 0);

        // Rotation counting: two wraps 0001->1000.
        drive(1'b0, 1'b1, 4'b0001);
        drive(1'b0, 1'b1, 4'b1000);
        drive(1'b0, 1'b1, 4'b0100);
        drive(1'b0, 1'b1, 4'b0010);
        drive(1'b0, 1'b1, 4'b0001);
        drive(1'b0, 1'b1, 4'b1000);
        pin_state("rot", 1, 3, 2, 0, 0);

        // Stall and gating.
        drive(1'b0, 1'b1, 4'b0100);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 4'b0100);
        pin_state("stall", 1, 2, 2, 0, 0);
        drive(1'b0, 1'b0, 4'b1111);
        pin_state("gate", 1, 2, 2, 0, 0);

        // Wrong successor while locked, then relock.
        drive(1'b0, 1'b1, 4'b0001);
        pin_state("wrongstep", 0, 2, 2, 1, 0);
        drive(1'b0, 1'b0, 4'b0001);
        chk("wrongstep.pulse_end", int'(step_err), 0);
        drive(1'b0, 1'b1, 4'b1000);
        drive(1'b0, 1'b1, 4'b0100);
        pin_state("relock", 1, 2, 2, 0, 0);

        // Illegal patterns.
        drive(1'b0, 1'b1, 4'b0000);
        pin_state("zero", 0, 2, 2, 0, 1);
        drive(1'b0, 1'b1, 4'b0110);
        pin_state("multihot", 0, 2, 2, 0, 1);
        drive(1'b0, 1'b1, 4'b0010);
        pin_state("search_exit", 0, 2, 2, 0, 0);

        // Reset mid-operation with rot_count = 5.
        drive(1'b1, 1'b0, 4'b0000);
        drive(1'b0, 1'b1, 4'b1000);
        drive(1'b0, 1'b1, 4'b0100);
        drive(1'b0, 1'b1, 4'b0010);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 4'b0001);
            drive(1'b0, 1'b1, 4'b1000);
            drive(1'b0, 1'b1, 4'b0100);
            drive(1'b0, 1'b1, 4'b0010);
        end
        pin_state("rot5", 1, 1, 5, 0, 0);
        drive(1'b1, 1'b1, 4'b0001);
        pin_state("midreset", 0, 0, 0, 0, 0);
        drive(1'b0, 1'b1, 4'b1000);
        pin_state("after_reset", 0, 0, 0, 0, 0);

        // Long clean run so rot_count wraps past 2^ROT_W.
        gen_pos = 3;
        for (int i = 0; i < 1100; i++) begin
            gen_pos = (gen_pos + W - 1) % W;
            v = 4'b0001 << gen_pos;
            drive(1'b0, 1'b1, v);
        end

        // Randomized mix of good steps, stalls, jumps, garbage, gating and resets.
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 65) begin
                gen_pos = (gen_pos + W - 1) % W;
                v = 4'b0001 << gen_pos;
                drive(1'b0, 1'b1, v);
            end else if (r < 75) begin
                v = 4'b0001 << gen_pos;
                drive(1'b0, 1'b1, v);
            end else if (r < 83) begin
                gen_pos = int'($urandom_range(0, W - 1));
                v = 4'b0001 << gen_pos;
                drive(1'b0, 1'b1, v);
            end else if (r < 90) begin
                v = 4'($urandom_range(0, 15));
                drive(1'b0, 1'b1, v);
            end else if (r < 98) begin
                v = 4'($urandom_range(0, 15));
                drive(1'b0, 1'b0, v);
            end else begin
                v = 4'($urandom_range(0, 15));
                drive(1'b1, 1'($urandom_range(0, 1)), v);
            end
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
